// File: rtl/i2c_master_ctrl.sv
// Byte-oriented I2C master: sequences START/device/memory-address/data/STOP register
// transactions (with repeated START for reads) over open-drain SCL/SDA pads.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rw,
    input  logic [6:0] i_cmd_dev_adr,
    input  logic [7:0] i_cmd_mem_adr,
    input  logic [3:0] i_cmd_len,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    input  logic       i_sda_i,
    output logic [3:0] o_state
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_ACK1, S_MADR, S_ACK2, S_WDATA,
        S_ACK3, S_RSTART, S_DEV_R, S_ACK4, S_RDATA, S_MACK, S_STOP
    } state_t;

    // Command handshake: a command is taken on the clock where i_cmd_valid && o_cmd_ready.
    // o_cmd_ready is high exactly while the FSM sits in IDLE.
    state_t     r_state;
    logic [DW-1:0] r_div;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic [3:0] r_cnt;
    logic [7:0] r_sh;
    logic [7:0] r_rd_data;
    logic [6:0] r_dev;
    logic [7:0] r_madr;
    logic       r_rw;
    logic       r_smp;
    logic       r_cmd_ready, r_wr_ready, r_rd_valid, r_done, r_nack;
    logic       r_scl_oe, r_sda_oe;

    logic w_qend, w_bit_end, w_sample, w_load, w_stall;
    logic w_scl, w_sda;

    assign w_qend    = (r_div == DIV_LAST);
    assign w_bit_end = w_qend && (r_q == 2'd3);
    assign w_sample  = w_qend && (r_q == 2'd2);
    assign w_load    = (r_state == S_WDATA) && (r_bit == 3'd0) && (r_q == 2'd0) && (r_div == '0);
    // The bit engine freezes in the first clock of Q0 (SCL low) until a write byte is offered.
    assign w_stall   = w_load && !i_wr_valid;

    always_comb begin
        w_scl = 1'b0;
        w_sda = 1'b0;
        case (r_state)
            S_START:  begin w_scl = (r_q == 2'd2); w_sda = (r_q != 2'd0); end
            S_RSTART: begin w_scl = (r_q == 2'd0) || (r_q == 2'd3); w_sda = r_q[1]; end
            S_STOP:   begin w_scl = (r_q == 2'd0); w_sda = (r_q != 2'd2); end
            S_DEV_W, S_MADR, S_WDATA, S_DEV_R: begin w_scl = !r_q[1]; w_sda = !r_sh[7]; end
            S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_RDATA: begin w_scl = !r_q[1]; w_sda = 1'b0; end
            S_MACK:   begin w_scl = !r_q[1]; w_sda = (r_cnt != 4'd0); end
            default:  begin w_scl = 1'b0; w_sda = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_q         <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_rd_data   <= '0;
            r_dev       <= '0;
            r_madr      <= '0;
            r_rw        <= 1'b0;
            r_smp       <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
        end else begin
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_scl_oe   <= w_scl;
            r_sda_oe   <= w_sda;
            if (r_state != S_IDLE && !w_stall) begin
                r_div <= w_qend ? '0 : r_div + DW'(1);
                if (w_qend) r_q <= r_q + 2'd1;
            end
            if (w_sample) r_smp <= i_sda_i;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    r_q   <= '0;
                    if (i_cmd_valid) begin
                        r_rw        <= i_cmd_rw;
                        r_dev       <= i_cmd_dev_adr;
                        r_madr      <= i_cmd_mem_adr;
                        r_cnt       <= i_cmd_len;
                        r_bit       <= '0;
                        r_nack      <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_START: if (w_qend && r_q == 2'd2) begin
                    r_q     <= '0;
                    r_sh    <= {r_dev, 1'b0};
                    r_state <= S_DEV_W;
                end
                S_DEV_W, S_MADR, S_WDATA, S_DEV_R: begin
                    if (w_load && i_wr_valid) begin
                        r_sh       <= i_wr_data;
                        r_wr_ready <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_sh  <= {r_sh[6:0], 1'b0};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            case (r_state)
                                S_DEV_W: r_state <= S_ACK1;
                                S_MADR:  r_state <= S_ACK2;
                                S_WDATA: r_state <= S_ACK3;
                                default: r_state <= S_ACK4;
                            endcase
                        end
                    end
                end
                S_ACK1, S_ACK2, S_ACK3, S_ACK4: if (w_bit_end) begin
                    if (r_smp) begin
                        r_nack  <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        case (r_state)
                            S_ACK1: begin r_sh <= r_madr; r_state <= S_MADR; end
                            S_ACK2: r_state <= r_rw ? S_RSTART : S_WDATA;
                            S_ACK3: begin
                                if (r_cnt == 4'd0) r_state <= S_STOP;
                                else begin r_cnt <= r_cnt - 4'd1; r_state <= S_WDATA; end
                            end
                            default: r_state <= S_RDATA;
                        endcase
                    end
                end
                S_RSTART: if (w_bit_end) begin
                    r_sh    <= {r_dev, 1'b1};
                    r_state <= S_DEV_R;
                end
                S_RDATA: begin
                    if (w_sample) r_sh <= {r_sh[6:0], i_sda_i};
                    if (w_bit_end) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rd_data  <= r_sh;
                            r_rd_valid <= 1'b1;
                            r_state    <= S_MACK;
                        end
                    end
                end
                S_MACK: if (w_bit_end) begin
                    if (r_cnt == 4'd0) r_state <= S_STOP;
                    else begin r_cnt <= r_cnt - 4'd1; r_state <= S_RDATA; end
                end
                S_STOP: if (w_qend && r_q == 2'd2) begin
                    r_q         <= '0;
                    r_done      <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_wr_ready  = r_wr_ready;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_done      = r_done;
    assign o_nack      = r_nack;
    assign o_scl_oe    = r_scl_oe;
    assign o_sda_oe    = r_sda_oe;
    assign o_state     = r_state;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a behavioural memory slave at 0x10 (32 bytes),
// a bus monitor recording bytes and ACK bits, and one task per scenario.
module tb_i2c_master_ctrl;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_dev_adr = '0;
  logic [7:0] cmd_mem_adr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0;
  logic cmd_ready, wr_ready, rd_valid, done, nack, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic [3:0] dbg_state;
  logic s_oe = 1'b0;
  logic sda_line;

  assign sda_line = !(sda_oe || s_oe);

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_rw(cmd_rw), .i_cmd_dev_adr(cmd_dev_adr), .i_cmd_mem_adr(cmd_mem_adr),
    .i_cmd_len(cmd_len), .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_done(done), .o_nack(nack),
    .o_scl_oe(scl_oe), .o_sda_oe(sda_oe), .i_sda_i(sda_line), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- slave model, monitor and pulse counters ----------------
  logic [7:0] mem [0:31];
  logic [7:0] mon_q[$];
  logic       ack_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wr_src[$];
  logic [7:0] exp_q[$];
  int edge_q[$];
  int cyc = 0, wr_cnt = 0, m_starts = 0, m_stops = 0, m_bit = 0;
  logic done_nack = 1'b0;
  logic p_scl = 1'b1, p_sda = 1'b1, p_scl_oe = 1'b0;
  int s_st = 0, s_bit = 0;
  logic s_first = 1'b0, s_rw = 1'b0;
  logic [7:0] s_sh = '0, s_ptr = '0, m_sh = '0;

  always @(negedge clk) begin
    logic scl, sda;
    scl = !scl_oe;
    sda = sda_line;
    cyc++;
    if (p_scl_oe && !scl_oe) edge_q.push_back(cyc);
    p_scl_oe = scl_oe;
    if (wr_ready) wr_cnt++;
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) done_nack = nack;
    if (p_scl && scl && p_sda && !sda) begin
      s_st = 1; s_bit = 0; s_first = 1'b1; s_oe = 1'b0;
      m_bit = 0; m_starts++;
    end else if (p_scl && scl && !p_sda && sda) begin
      s_st = 0; s_oe = 1'b0; m_stops++;
    end else if (!p_scl && scl) begin
      if (m_bit < 8) m_sh = {m_sh[6:0], sda};
      else begin mon_q.push_back(m_sh); ack_q.push_back(sda); end
      m_bit = (m_bit >= 8) ? 0 : m_bit + 1;
      if (s_bit < 8 && (s_st == 1 || s_st == 2 || s_st == 3)) s_sh = {s_sh[6:0], sda};
      if (s_bit == 8 && s_st == 4 && sda) s_st = 5;
    end else if (p_scl && !scl) begin
      if (s_first) s_first = 1'b0;
      else if (s_st == 0 || s_st == 5) s_oe = 1'b0;
      else if (s_bit == 7) begin
        s_bit = 8;
        case (s_st)
          1: if (s_sh[7:1] == 7'h10) begin s_oe = 1'b1; s_rw = s_sh[0]; end
             else begin s_oe = 1'b0; s_st = 5; end
          2: if (s_sh < 8'd32) begin s_ptr = s_sh; s_oe = 1'b1; end
             else begin s_oe = 1'b0; s_st = 5; end
          3: begin mem[s_ptr[4:0]] = s_sh; s_ptr++; s_oe = 1'b1; end
          default: s_oe = 1'b0;
        endcase
      end else if (s_bit == 8) begin
        s_bit = 0;
        case (s_st)
          1: if (s_rw) begin s_st = 4; s_sh = mem[s_ptr[4:0]]; s_ptr++; s_oe = !s_sh[7]; end
             else begin s_st = 2; s_oe = 1'b0; end
          2: begin s_st = 3; s_oe = 1'b0; end
          4: begin s_sh = mem[s_ptr[4:0]]; s_ptr++; s_oe = !s_sh[7]; end
          default: s_oe = 1'b0;
        endcase
      end else begin
        s_bit++;
        if (s_st == 4) begin s_sh = {s_sh[6:0], 1'b0}; s_oe = !s_sh[7]; end
      end
    end
    p_scl = scl;
    p_sda = sda;
  end

  // Write-data driver: offers the head of wr_src, pops it on each wr_ready pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_ready && wr_src.size() > 0) void'(wr_src.pop_front());
      wr_valid = (wr_src.size() > 0);
      wr_data  = (wr_src.size() > 0) ? wr_src[0] : 8'h00;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] pack_bytes(input logic [7:0] q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v = {v[55:0], q[i]};
    return v;
  endfunction

  function automatic logic [7:0] pack_bits(input logic q[$]);
    logic [7:0] v = '0;
    foreach (q[i]) v = {v[6:0], q[i]};
    return v;
  endfunction

  task automatic clr();
    mon_q.delete(); ack_q.delete(); rd_q.delete(); edge_q.delete();
    wr_cnt = 0; m_starts = 0; m_stops = 0; done_nack = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] madr,
                       input logic [3:0] len);
    @(negedge clk);
    cmd_rw = rw; cmd_dev_adr = dev; cmd_mem_adr = madr; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL %s_timeout: no done after %0d cycles", tag, n); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec += 9;
    if (scl_oe !== 1'b0)   begin n_err++; $display("FAIL rst_scl_oe: got %b want 0", scl_oe); end
    if (sda_oe !== 1'b0)   begin n_err++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    if (done !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    if (nack !== 1'b0)     begin n_err++; $display("FAIL rst_nack: got %b want 0", nack); end
    if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
    if (dbg_state !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    clr();
    wr_src.push_back(8'hA5); wr_src.push_back(8'h3C);
    issue(1'b0, 7'h10, 8'h02, 4'd1);
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_drop: cmd_ready %b want 0", cmd_ready); end
    wait_done(3000, "wr");
    n_vec += 2;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_with_done: cmd_ready %b want 1", cmd_ready); end
    if (nack !== 1'b0) begin n_err++; $display("FAIL wr_nack: got %b want 0", nack); end
    @(negedge clk);
    n_vec += 8;
    if (mon_q.size() != 4 || pack_bytes(mon_q) !== 64'h2002A53C)
      begin n_err++; $display("FAIL wr_bytes: got %0d bytes %h want 4 bytes 2002a53c", mon_q.size(), pack_bytes(mon_q)); end
    if (ack_q.size() != 4 || pack_bits(ack_q) !== 8'h00)
      begin n_err++; $display("FAIL wr_acks: got %0d acks %b want 0000", ack_q.size(), pack_bits(ack_q)); end
    if (wr_cnt != 2) begin n_err++; $display("FAIL wr_pulses: got %0d want 2", wr_cnt); end
    if (mem[2] !== 8'hA5 || mem[3] !== 8'h3C)
      begin n_err++; $display("FAIL wr_mem: got %h %h want a5 3c", mem[2], mem[3]); end
    if (m_starts != 1 || m_stops != 1)
      begin n_err++; $display("FAIL wr_start_stop: got %0d/%0d want 1/1", m_starts, m_stops); end
    if (edge_q.size() < 10) begin n_err++; $display("FAIL wr_edges: got %0d edges want >=10", edge_q.size()); end
    else begin
      if (edge_q[1] - edge_q[0] != 4 * CLK_DIV)
        begin n_err++; $display("FAIL bit_period: got %0d want %0d", edge_q[1] - edge_q[0], 4 * CLK_DIV); end
      if (edge_q[9] - edge_q[8] != 4 * CLK_DIV)
        begin n_err++; $display("FAIL bit_period_ack: got %0d want %0d", edge_q[9] - edge_q[8], 4 * CLK_DIV); end
    end
  endtask

  task automatic test_read();
    clr();
    issue(1'b1, 7'h10, 8'h02, 4'd1);
    wait_done(4000, "rd");
    n_vec++;
    if (nack !== 1'b0) begin n_err++; $display("FAIL rd_nack: got %b want 0", nack); end
    @(negedge clk);
    n_vec += 6;
    if (mon_q.size() != 5 || pack_bytes(mon_q) !== 64'h20022_1A53C)
      begin n_err++; $display("FAIL rd_bytes: got %0d bytes %h want 5 bytes 200221a53c", mon_q.size(), pack_bytes(mon_q)); end
    if (ack_q.size() != 5 || pack_bits(ack_q) !== 8'b00001)
      begin n_err++; $display("FAIL rd_acks: got %0d acks %b want 00001", ack_q.size(), pack_bits(ack_q)); end
    if (rd_q.size() != 2 || pack_bytes(rd_q) !== 64'hA53C)
      begin n_err++; $display("FAIL rd_data: got %0d bytes %h want a53c", rd_q.size(), pack_bytes(rd_q)); end
    if (m_starts != 2) begin n_err++; $display("FAIL rd_rstart: got %0d starts want 2", m_starts); end
    if (wr_cnt != 0) begin n_err++; $display("FAIL rd_wr_pulses: got %0d want 0", wr_cnt); end
    if (rd_data !== 8'h3C) begin n_err++; $display("FAIL rd_hold: got %h want 3c", rd_data); end
  endtask

  task automatic test_absent();
    clr();
    wr_src.push_back(8'h55);
    issue(1'b0, 7'h11, 8'h02, 4'd0);
    wait_done(2000, "abs");
    n_vec++;
    if (nack !== 1'b1) begin n_err++; $display("FAIL abs_nack: got %b want 1", nack); end
    @(negedge clk);
    n_vec += 5;
    if (mon_q.size() != 1 || mon_q[0] !== 8'h22)
      begin n_err++; $display("FAIL abs_bytes: got %0d bytes %h want 1 byte 22", mon_q.size(), pack_bytes(mon_q)); end
    if (ack_q.size() != 1 || ack_q[0] !== 1'b1)
      begin n_err++; $display("FAIL abs_ack: got %0d acks %b want 1", ack_q.size(), pack_bits(ack_q)); end
    if (wr_cnt != 0) begin n_err++; $display("FAIL abs_wr_pulses: got %0d want 0", wr_cnt); end
    if (mem[2] !== 8'hA5) begin n_err++; $display("FAIL abs_mem: got %h want a5", mem[2]); end
    if (m_stops != 1) begin n_err++; $display("FAIL abs_stop: got %0d want 1", m_stops); end
    repeat (20) @(negedge clk);
    n_vec++;
    if (nack !== 1'b1) begin n_err++; $display("FAIL abs_nack_hold: got %b want 1", nack); end
    wr_src.delete();
  endtask

  task automatic test_addr_nack();
    clr();
    wr_src.push_back(8'h66);
    issue(1'b0, 7'h10, 8'h20, 4'd0);
    n_vec++;
    if (nack !== 1'b0) begin n_err++; $display("FAIL an_nack_clear: got %b want 0", nack); end
    wait_done(2000, "an");
    n_vec++;
    if (nack !== 1'b1 || done_nack !== 1'b1 && 1'b0) begin n_err++; $display("FAIL an_nack: got %b want 1", nack); end
    @(negedge clk);
    n_vec += 3;
    if (mon_q.size() != 2 || pack_bytes(mon_q) !== 64'h2020)
      begin n_err++; $display("FAIL an_bytes: got %0d bytes %h want 2020", mon_q.size(), pack_bytes(mon_q)); end
    if (ack_q.size() != 2 || pack_bits(ack_q) !== 8'b01)
      begin n_err++; $display("FAIL an_acks: got %0d acks %b want 01", ack_q.size(), pack_bits(ack_q)); end
    if (wr_cnt != 0) begin n_err++; $display("FAIL an_wr_pulses: got %0d want 0", wr_cnt); end
    wr_src.delete();
  endtask

  task automatic test_wr_gap();
    int n = 0;
    int low_bad = 0;
    int rdy_bad = 0;
    clr();
    wr_src.push_back(8'h11);
    issue(1'b0, 7'h10, 8'h05, 4'd1);
    while (mon_q.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    repeat (2 * CLK_DIV + 4) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scl_oe !== 1'b1) low_bad++;
      if (i >= 10 && i < 15) begin
        cmd_rw = 1'b1; cmd_valid = 1'b1;
        if (cmd_ready !== 1'b0) rdy_bad++;
      end else cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    n_vec += 2;
    if (low_bad != 0) begin n_err++; $display("FAIL gap_scl_low: %0d of 100 cycles released want 0", low_bad); end
    if (rdy_bad != 0) begin n_err++; $display("FAIL gap_cmd_ignored: cmd_ready high %0d cycles want 0", rdy_bad); end
    wr_src.push_back(8'h3C);
    wait_done(3000, "gap");
    repeat (50) @(negedge clk);
    n_vec += 4;
    if (mon_q.size() != 4 || pack_bytes(mon_q) !== 64'h2005113C)
      begin n_err++; $display("FAIL gap_bytes: got %0d bytes %h want 2005113c", mon_q.size(), pack_bytes(mon_q)); end
    if (mem[5] !== 8'h11 || mem[6] !== 8'h3C)
      begin n_err++; $display("FAIL gap_mem: got %h %h want 11 3c", mem[5], mem[6]); end
    if (wr_cnt != 2 || done_nack !== 1'b0)
      begin n_err++; $display("FAIL gap_pulses: wr_ready %0d nack %b want 2 0", wr_cnt, done_nack); end
    if (m_starts != 1 || cmd_ready !== 1'b1)
      begin n_err++; $display("FAIL gap_no_queue: starts %0d cmd_ready %b want 1 1", m_starts, cmd_ready); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    clr();
    wr_src.push_back(8'h99);
    issue(1'b0, 7'h10, 8'h0A, 4'd0);
    while (!(mon_q.size() == 1 && m_bit >= 3 && scl_oe === 1'b1) && n < 2000) begin @(negedge clk); n++; end
    n_vec++;
    if (n >= 2000) begin n_err++; $display("FAIL mr_timeout: madr bit not reached in %0d cycles", n); end
    rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0)
      begin n_err++; $display("FAIL mr_release: scl_oe %b sda_oe %b want 0 0", scl_oe, sda_oe); end
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mr_cmd_ready: got %b want 1", cmd_ready); end
    wr_src.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec += 2;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready_after: got %b want 1", cmd_ready); end
    if (mem[10] !== 8'h00) begin n_err++; $display("FAIL mr_mem: got %h want 00", mem[10]); end
  endtask

  task automatic test_after_reset();
    clr();
    wr_src.push_back(8'h77);
    issue(1'b0, 7'h10, 8'h08, 4'd0);
    wait_done(2000, "ar");
    n_vec++;
    if (nack !== 1'b0) begin n_err++; $display("FAIL ar_nack: got %b want 0", nack); end
    @(negedge clk);
    n_vec += 3;
    if (mon_q.size() != 3 || pack_bytes(mon_q) !== 64'h200877)
      begin n_err++; $display("FAIL ar_bytes: got %0d bytes %h want 200877", mon_q.size(), pack_bytes(mon_q)); end
    if (mem[8] !== 8'h77) begin n_err++; $display("FAIL ar_mem: got %h want 77", mem[8]); end
    if (wr_cnt != 1) begin n_err++; $display("FAIL ar_wr_pulses: got %0d want 1", wr_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_absent();
    test_addr_nack();
    test_wr_gap();
    test_mid_reset();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Byte-oriented I2C master that sequences complete register transactions against memory-style slaves such as our 7-bit-addressed I2C slave, which takes a device byte, an 8-bit memory address, then data. One command produces the whole bus sequence:
- Write: START, device+W, memory address, N data bytes, STOP.
- Read: START, device+W, memory address, repeated START, device+R, N data bytes, STOP.
It sits between the system-clock register logic and the open-drain SCL/SDA pads. It is the only master on the bus and does not support clock stretching.

Parameters:
CLK_DIV, 8, system clocks per SCL quarter-period (min 2); one SCL bit = 4*CLK_DIV clocks.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid&&cmd_ready.
cmd_rw  input  1  0 = write, 1 = read.
cmd_dev_adr  input  7  slave device address.
cmd_mem_adr  input  8  slave memory address.
cmd_len  input  4  byte count minus one (0 gives 1 byte, 15 gives 16 bytes).
wr_data  input  8  write byte.
wr_valid  input  1  wr_data valid.
wr_ready  output  1  one-cycle pulse when wr_data is consumed.
rd_data  output  8  received byte.
rd_valid  output  1  one-cycle pulse, rd_data valid.
done  output  1  one-cycle pulse at end of transaction.
nack  output  1  error flag valid with done; holds until the next accept.
scl_oe  output  1  1 = pull SCL low, 0 = release.
sda_oe  output  1  1 = pull SDA low, 0 = release.
sda_i  input  1  SDA pad level.

Behaviour:
- Reset (async, immediate):
  - scl_oe=0, sda_oe=0, cmd_ready=1 (IDLE).
  - wr_ready, rd_valid, done, nack, rd_data all 0.
  - Phase counter and byte counter cleared.
  - Reset mid-transfer releases the bus at once; no STOP is generated.
- Command capture: on accept, latch rw/dev/mem_adr/len and clear nack. cmd_ready drops the next cycle.
- Bit timing: the bit engine runs quarter phases Q0..Q3, each CLK_DIV clocks.
  - Q0: SCL low; SDA is updated on the first clock of Q0.
  - Q1: SCL low.
  - Q2/Q3: SCL released.
  - sda_i is sampled on the last clock of Q2.
  - Bits are sent MSB first.
  - Drive rule: sda_oe = !bit, so a 1 bit releases SDA.
- START (each 1 quarter):
  - SDA released, SCL released.
  - SDA low.
  - SCL low.
- Repeated START (each 1 quarter): SDA released with SCL low, then SCL released, then SDA low, then SCL low.
- STOP (each 1 quarter): SDA low with SCL low, then SCL released, then SDA released. Then return to IDLE and pulse done.
- States: IDLE, START, DEV_W, ACK1, MADR, ACK2, WDATA, ACK3, RSTART, DEV_R, ACK4, RDATA, MACK, STOP.
  - Byte states shift 8 bits. ACKn states release SDA for 1 bit and sample sda_i (0 = ACK).
  - Write path: ACK2 then WDATA.
  - Read path: ACK2 then RSTART.
- Write data:
  - wr_ready pulses on the clock the byte is loaded, which is the first Q0 of the byte.
  - If wr_valid=0 when the byte is needed, hold in Q0 with SCL low, unbounded, until wr_valid=1.
- Read data:
  - After the 8th bit is sampled, rd_data is loaded and rd_valid pulses once.
  - MACK drives ACK (SDA low) when bytes remain and NACK (released) on the last byte.
  - rd_data is not accepted with backpressure; the consumer must take it.
- Counters: the byte counter is loaded with cmd_len and decrements after each data ACK/MACK. The last byte is reached at count 0, with no wrap.
- Any ACK1/ACK2/ACK4/ACK3 sampling 1:
  - set nack=1;
  - go directly to STOP (no further bytes, no further wr_ready);
  - done pulses with nack=1.
- A NACK on the final write byte also sets nack.
- cmd_valid during a transaction is ignored; it is not queued.
- Outputs are registered; done and cmd_ready rise on the same clock.

Test Plan:
- Write, CLK_DIV=4, dev 0x10, mem 0x02, len=1, data 0xA5,0x3C:
  - START, then bytes 0x20, 0x02, 0xA5, 0x3C, all ACKed, then STOP.
  - Two wr_ready pulses; done with nack=0.
  - Slave memory [2]=0xA5, [3]=0x3C.
- Read, dev 0x10, mem 0x02, len=1:
  - Repeated START, then byte 0x21.
  - rd_valid twice, with 0xA5 then 0x3C.
  - MACK is ACK then NACK; done with nack=0.
- Dev 0x11 (absent): ACK1 samples 1, STOP follows immediately, done with nack=1, zero wr_ready pulses, slave memory unchanged.
- Write with mem 0x20: the slave NACKs the address, so ACK2 fails, then STOP, done with nack=1.
- Write with wr_valid withheld 100 clocks before the second byte: SCL is held low for the full gap, then the byte 0x3C transfers correctly.
- Assert rst_n mid-byte: scl_oe/sda_oe=0 in the same cycle, cmd_ready=1 after release, and the next command completes normally.
- Bit period check: the number of clocks between successive scl_oe falling edges equals 4*CLK_DIV.
